// File: rtl/header_extract.sv
// header_extract: pulls the IPv4 5-tuple out of a 64-bit Ethernet stream and issues it paced by GAP.
// Ports: clk/rst (sync, active-high); s_tdata/s_tvalid/s_tlast/s_tready stream in (never stalls);
// enable gates issue; idata/ivalid tuple out; pkt_cnt/drop_cnt stats, live only with HDR_EXTRACT_STATS_EN.
module header_extract #(
  parameter int GAP = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  s_tdata,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  input  logic         enable,
  output logic [103:0] idata,
  output logic         ivalid,
  output logic [31:0]  pkt_cnt,
  output logic [15:0]  drop_cnt
);
  typedef enum logic [2:0] {W0, W1, W2, W3, W4, SKIP} state_t;
  localparam int PW = GAP > 1 ? $clog2(GAP) : 1;
  state_t st, nxt;
  logic [7:0] proto;
  logic [31:0] src;
  logic [15:0] dst_hi;
  logic [103:0] hold, last, tuple;
  logic [PW-1:0] pace;
  logic full, done, issue, accept, hdr_ok, l4;
  assign s_tready = 1'b1;
  // Tuple is assembled directly from the W4 word so it lands in the holding register on that edge.
  always_comb begin
    hdr_ok = s_tdata[31:16] == 16'h0800 && s_tdata[15:8] == 8'h45;
    l4 = proto == 8'd6 || proto == 8'd17;
    tuple = {src, dst_hi, s_tdata[63:48], l4 ? s_tdata[47:16] : 32'h0, proto};
    done = s_tvalid && st == W4;
    issue = !rst && full && enable && pace == '0;
    accept = done && (!full || issue);
    nxt = !s_tvalid ? st : s_tlast ? W0 :
          st == W0 ? W1 : st == W1 ? (hdr_ok ? W2 : SKIP) :
          st == W2 ? W3 : st == W3 ? W4 : SKIP;
  end
  assign ivalid = issue;
  assign idata = rst ? '0 : issue ? hold : last;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= W0;
      full <= 1'b0;
      pace <= '0;
      last <= '0;
    end else begin
      st <= nxt;
      full <= done || (full && !issue);
      if (s_tvalid && st == W2) proto <= s_tdata[7:0];
      if (s_tvalid && st == W3) {src, dst_hi} <= s_tdata[47:0];
      if (accept) hold <= tuple;
      if (issue) last <= hold;
      pace <= issue ? PW'(GAP - 1) : pace != '0 ? pace - PW'(1) : pace;
    end
  end
`ifdef HDR_EXTRACT_STATS_EN
  logic [31:0] pkt_q;
  logic [15:0] drop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q <= '0;
      drop_q <= '0;
    end else begin
      if (accept) pkt_q <= pkt_q + 32'd1;
      if (done && !accept && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
  assign pkt_cnt = pkt_q;
  assign drop_cnt = drop_q;
`else
  assign pkt_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule
